// File: rtl/window_stream_pkg.sv
// Shared types and helpers for the K-row line-buffer sequencer.
package window_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // A KxK window needs at least K lines before it can ever be complete.
    function automatic int unsigned min_height(input int unsigned kernel);
        return kernel;
    endfunction

endpackage

// File: rtl/window_stream_ctrl_counter_roll.sv
// Up-counter that wraps to zero after max_val_i; mirrors the buffer's address counter.
module counter_roll #(
    parameter int Width = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             up_i,
    input  logic [Width-1:0] max_val_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (up_i) begin
            count_q <= (count_q == max_val_i) ? '0 : count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/window_stream_ctrl.sv
// Gates a pixel stream into a K-row line buffer, masks warm-up windows and
// flushes the buffer back to column 0 on abort.
module window_stream_ctrl
    import window_stream_pkg::*;
#(
    parameter  int Width       = 8,
    parameter  int LineWidth   = 8,
    parameter  int KernelSize  = 3,
    parameter  int HeightWidth = 10,
    localparam int ColWidth    = $clog2(LineWidth)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [HeightWidth-1:0] height_i,
    input  logic                   abort_i,
    input  logic [Width-1:0]       in_data_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [Width-1:0]       buf_data_o,
    output logic                   buf_valid_o,
    input  logic                   buf_ready_i,
    output logic                   win_valid_o,
    output logic                   win_last_o,
    output logic [HeightWidth-1:0] row_o,
    output logic [ColWidth-1:0]    col_o,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic                   abort_done_o,
    output logic                   err_o
);

    localparam logic [HeightWidth-1:0] KRow    = HeightWidth'(KernelSize - 1);
    localparam logic [ColWidth-1:0]    KCol    = ColWidth'(KernelSize - 1);
    localparam logic [ColWidth-1:0]    LastCol = ColWidth'(LineWidth - 1);
    localparam logic [HeightWidth-1:0] MinRows = HeightWidth'(min_height(KernelSize));

    state_e                 state_q, state_d;
    logic [HeightWidth-1:0] row_q, height_q;
    logic [ColWidth-1:0]    col;
    logic                   frame_done_q, abort_done_q, err_q;
    logic                   frame_done_d, abort_done_d, err_d;
    logic                   load, row_inc, col_up, fire;
    logic                   last_col, last_row;

    assign last_col = (col == LastCol);
    assign last_row = (row_q == height_q - 1'b1);

    // Reloading on start keeps the column aligned with the buffer pointer.
    counter_roll #(
        .Width(ColWidth)
    ) u_col (
        .clk_i    (clk_i),
        .rst_i    (~rst_ni | load),
        .up_i     (col_up),
        .max_val_i(LastCol),
        .count_o  (col)
    );

    always_comb begin
        state_d      = state_q;
        in_ready_o   = 1'b0;
        buf_valid_o  = 1'b0;
        buf_data_o   = '0;
        win_valid_o  = 1'b0;
        win_last_o   = 1'b0;
        fire         = 1'b0;
        col_up       = 1'b0;
        load         = 1'b0;
        row_inc      = 1'b0;
        frame_done_d = 1'b0;
        abort_done_d = 1'b0;
        err_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (height_i >= MinRows) begin
                        load    = 1'b1;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort_i) begin
                    // Pixel is refused in the abort cycle so the buffer sees no write.
                    if (col == '0) begin
                        state_d      = IDLE;
                        abort_done_d = 1'b1;
                    end else begin
                        state_d = FLUSH;
                    end
                end else begin
                    in_ready_o  = buf_ready_i;
                    buf_valid_o = in_valid_i;
                    buf_data_o  = in_data_i;
                    fire        = in_valid_i & buf_ready_i;
                    col_up      = fire;
                    win_valid_o = fire & (row_q >= KRow) & (col >= KCol);
                    win_last_o  = win_valid_o & last_row & last_col;
                    if (fire && last_col) begin
                        if (last_row) begin
                            state_d      = IDLE;
                            frame_done_d = 1'b1;
                        end else begin
                            row_inc = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                buf_valid_o = 1'b1;
                col_up      = buf_ready_i;
                if (buf_ready_i && last_col) begin
                    state_d      = IDLE;
                    abort_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            row_q        <= '0;
            height_q     <= '0;
            frame_done_q <= 1'b0;
            abort_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= frame_done_d;
            abort_done_q <= abort_done_d;
            err_q        <= err_d;
            if (load) begin
                height_q <= height_i;
                row_q    <= '0;
            end else if (row_inc) begin
                row_q <= row_q + 1'b1;
            end
        end
    end

    assign row_o        = row_q;
    assign col_o        = col;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = frame_done_q;
    assign abort_done_o = abort_done_q;
    assign err_o        = err_q;

endmodule

// File: doc/window_stream_ctrl.md
Name: window_stream_ctrl

Overview:
Sequencer placed in front of a multi_delay_buffer configured as a K-row line buffer (Delay = LineWidth, BufferCnt = KernelSize-1).
- Gates the pixel stream into the buffer and tracks row/column position.
- Masks warm-up so window_valid_o asserts only when a full KxK neighbourhood is present.
- On abort, flushes the buffer with zero pixels until its internal address pointer realigns to column 0, keeping the buffer coherent for the next frame.

Parameters:
Width, 8, pixel width in bits.
LineWidth, 8, pixels per line; must equal the buffer Delay.
KernelSize, 3, window height/width; buffer BufferCnt = KernelSize-1.
HeightWidth, 10, width of the frame-height config and row counter.
ColWidth (localparam), $clog2(LineWidth), width of the column counter.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  synchronous active-low reset.
start_i  in  1  begin a frame; sampled only in IDLE.
height_i  in  HeightWidth  frame height in lines; latched on an accepted start_i.
abort_i  in  1  terminate the current frame; sampled only in RUN.
in_data_i  in  Width  upstream pixel.
in_valid_i  in  1  upstream valid.
in_ready_o  out  1  upstream ready.
buf_data_o  out  Width  to buffer data_i.
buf_valid_o  out  1  to buffer valid_i.
buf_ready_i  in  1  from buffer ready_o (the downstream ready, passed through).
win_valid_o  out  1  current buffer output plus in_data form a complete window.
win_last_o  out  1  last window of the frame.
row_o  out  HeightWidth  row of the current pixel.
col_o  out  ColWidth  column of the current pixel.
busy_o  out  1  state != IDLE.
frame_done_o  out  1  one-cycle pulse after the last pixel is accepted.
abort_done_o  out  1  one-cycle pulse when the flush completes.
err_o  out  1  one-cycle pulse when start_i is rejected.

Behaviour:
- Reset (rst_ni low at a posedge): state=IDLE, row=col=0, height register=0, all pulses 0. Reset is synchronous only; it has no effect without a clock edge. The buffer must share this reset (inverted) so its pointer also returns to 0.
- State machine: IDLE, RUN, FLUSH.
- IDLE:
  - in_ready_o=0, buf_valid_o=0, win_valid_o=0.
  - start_i with height_i >= KernelSize: latch height, row=col=0, go to RUN.
  - start_i with height_i < KernelSize: err_o pulses the next cycle; remain in IDLE.
  - abort_i is ignored.
- RUN:
  - buf_valid_o=in_valid_i; in_ready_o=buf_ready_i; buf_data_o=in_data_i.
  - fire = in_valid_i & buf_ready_i.
  - On fire: if col==LineWidth-1 then col=0 and row++, else col++.
  - Counters hold when there is no fire.
  - win_valid_o = fire & (row >= KernelSize-1) & (col >= KernelSize-1). Combinational, zero latency, aligned with the buffer's combinational valid_o.
  - win_last_o = win_valid_o & row==height-1 & col==LineWidth-1.
  - Fire on the last pixel: go to IDLE; frame_done_o pulses the next cycle.
  - start_i is ignored in RUN.
  - abort_i: if col==0, go to IDLE immediately and pulse abort_done_o. Otherwise go to FLUSH. abort_i takes priority over a simultaneous fire; the pixel is not accepted because in_ready_o is forced 0 in the abort cycle.
- FLUSH:
  - in_ready_o=0, buf_valid_o=1, buf_data_o=0, win_valid_o=0.
  - col advances on buf_ready_i.
  - Fire at col==LineWidth-1: col=0, go to IDLE, abort_done_o pulses the next cycle.
  - Rows are not counted.
- row_o/col_o always reflect the registered counters. Widths are truncated explicitly; row never exceeds height-1.

Decomposition:
- window_stream_pkg:
  - state_e enum {IDLE, RUN, FLUSH}.
  - Helper function min_height(KernelSize).
- Column counter: instantiate the existing counter_roll sub-module (max_val_i = LineWidth-1, up_i = fire, rst_i = ~rst_ni | load), so its wrap matches the buffer's address counter.
- Row counter and FSM are inline.

Test Plan:
(All with LineWidth=8, KernelSize=3.)
1. start, height=4; 32 pixels back-to-back with buf_ready_i=1 -> win_valid_o high exactly 12 times (rows 2-3, cols 2-7); win_last_o on pixel 31; frame_done_o pulses one cycle later; busy_o drops.
2. Same frame with buf_ready_i toggling every cycle -> still 12 windows at the same (row,col); counters hold in stall cycles; in_ready_o equals buf_ready_i.
3. abort_i at row 1, col 5 -> 3 zero words to the buffer (cols 5,6,7); in_ready_o=0; abort_done_o pulse; next frame's first pixel reports col 0 and the buffer pointer is at 0.
4. start with height=2 -> err_o pulses once; state stays IDLE; in_ready_o=0. start with height=3 -> accepted.
5. rst_ni low for one edge mid-RUN at row 2, col 4 -> next cycle busy_o=0, row=col=0, buf_valid_o=0; subsequent start works normally.
6. start_i held high through RUN and abort_i pulsed in IDLE -> both ignored; frame completes with 12 windows.
